// File: rtl/if_fetch_if.sv
// if_fetch_if: bundle between fetch, instruction memory and decode.
// master = fetch stage; slave = memory/decode/execute side.
interface if_fetch_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        stall_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        id_en_o;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ack_i,
    input  imem_data_i,
    input  redirect_i,
    input  redirect_pc_i,
    input  stall_i,
    output inst_o,
    output pc_o,
    output id_en_o
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ack_i,
    output imem_data_i,
    output redirect_i,
    output redirect_pc_i,
    output stall_i,
    input  inst_o,
    input  pc_o,
    input  id_en_o
  );
endinterface

// File: rtl/if_fetch.sv
// if_fetch: RV32 fetch stage, PC + one-outstanding imem request + prefetch FIFO.
// Ports: clk, rst (async active-low), bus (if_fetch_if.master: imem, redirect, stall, decode out).
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input logic        clk,
  input logic        rst,
  if_fetch_if.master bus
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_FULL  = 2'd1;
  localparam logic [1:0] S_KILL  = 2'd2;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CAP  = CW'(DEPTH);

  logic [1:0]    state_q, state_d;
  logic          run_q;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   kill_addr_q;
  logic [31:0]   fifo_pc   [DEPTH];
  logic [31:0]   fifo_inst [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   inst_q, pc_q;
  logic          id_en_q;
  logic          ack, push, pop;
  logic          kill_done, drain;
  logic [31:0]   tgt;
  logic          unused_lsb;

  assign tgt        = {bus.redirect_pc_i[31:2], 2'b00};
  assign unused_lsb = ^bus.redirect_pc_i[1:0];

  // run_q keeps the request low until the first edge after reset release
  assign bus.imem_req_o  = run_q && (state_q != S_FULL);
  // KILL keeps presenting the cancelled address until its ack returns
  assign bus.imem_addr_o = (state_q == S_KILL) ? kill_addr_q : fetch_pc_q;

  assign ack  = bus.imem_ack_i && bus.imem_req_o;
  assign push = ack && (state_q == S_FETCH) && !bus.redirect_i;
  assign pop  = (cnt_q != '0) && !bus.stall_i && !bus.redirect_i;

  always_comb begin
    cnt_d = cnt_q;
    if (bus.redirect_i)
      cnt_d = '0;
    else
      cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  assign kill_done = !bus.redirect_i && (state_q == S_KILL) && ack;
  assign drain     = !bus.redirect_i && (state_q == S_FULL) && (cnt_d != CAP);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    unique case (1'b1)
      bus.redirect_i: begin
        fetch_pc_d = tgt;
        state_d    = (bus.imem_req_o && !ack) ? S_KILL : S_FETCH;
      end
      push: begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        state_d    = (cnt_d == CAP) ? S_FULL : S_FETCH;
      end
      kill_done: state_d = S_FETCH;
      drain:     state_d = S_FETCH;
      default: ;
    endcase
  end

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_FETCH;
      run_q       <= 1'b0;
      fetch_pc_q  <= RESET_PC;
      kill_addr_q <= RESET_PC;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q    <= state_d;
      run_q      <= 1'b1;
      fetch_pc_q <= fetch_pc_d;
      cnt_q      <= cnt_d;
      if (state_q != S_KILL)
        kill_addr_q <= fetch_pc_q;
      if (bus.redirect_i) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= inc(wr_ptr_q);
        if (pop)  rd_ptr_q <= inc(rd_ptr_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr_q]   <= fetch_pc_q;
      fifo_inst[wr_ptr_q] <= bus.imem_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_q  <= '0;
      pc_q    <= '0;
      id_en_q <= 1'b0;
    end else begin
      id_en_q <= pop;
      if (pop) begin
        inst_q <= fifo_inst[rd_ptr_q];
        pc_q   <= fifo_pc[rd_ptr_q];
      end
    end
  end

  assign bus.inst_o  = inst_q;
  assign bus.pc_o    = pc_q;
  assign bus.id_en_o = id_en_q;

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed scenarios + random traffic for if_fetch.
// Checks every cycle against a queue-based fetch model.
module tb_if_fetch;
  localparam logic [31:0] RPC = 32'h100;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  if_fetch_if bus();

  if_fetch #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;
  int obs_acks = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc, m_stale, m_inst, m_pco;
  bit          m_cancel, m_started, m_en;

  function automatic bit m_req();
    return m_started && (m_cancel || q.size() < DEPTH);
  endfunction

  function automatic logic [31:0] m_addr();
    return m_cancel ? m_stale : m_pc;
  endfunction

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  task automatic m_reset();
    q.delete();
    m_pc = RPC; m_stale = RPC;
    m_cancel = 0; m_started = 0; m_en = 0;
    m_inst = '0; m_pco = '0;
  endtask

  task automatic m_step(bit ack, logic [31:0] data, bit redir,
                        logic [31:0] rpc, bit stall);
    bit req, take, pop;
    ent_t h;
    req  = m_req();
    take = ack && req;
    pop  = (q.size() != 0) && !stall && !redir;
    m_en = pop;
    if (pop) begin
      h = q.pop_front();
      m_inst = h.inst;
      m_pco  = h.pc;
    end
    if (redir) begin
      if (req && !take) begin
        if (!m_cancel) m_stale = m_pc;
        m_cancel = 1;
      end else begin
        m_cancel = 0;
      end
      q.delete();
      m_pc = {rpc[31:2], 2'b00};
    end else if (m_cancel) begin
      if (take) m_cancel = 0;
    end else if (take) begin
      q.push_back('{pc: m_pc, inst: data});
      m_pc = m_pc + 32'd4;
    end
    m_started = 1;
  endtask

  task automatic cyc(bit ack, logic [31:0] data, bit redir,
                     logic [31:0] rpc, bit stall);
    bus.imem_ack_i    = ack;
    bus.imem_data_i   = data;
    bus.redirect_i    = redir;
    bus.redirect_pc_i = rpc;
    bus.stall_i       = stall;
    if (ack && bus.imem_req_o) obs_acks++;
    @(posedge clk);
    if (rst) m_step(ack, data, redir, rpc, stall);
    @(negedge clk);
    chk("req", {31'd0, bus.imem_req_o}, {31'd0, m_req()});
    if (m_req() || !rst) chk("addr", bus.imem_addr_o, m_addr());
    chk("id_en", {31'd0, bus.id_en_o}, {31'd0, m_en});
    chk("inst", bus.inst_o, m_inst);
    chk("pc", bus.pc_o, m_pco);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(0, '0, 0, '0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    m_reset();
    idle(2);
    rst = 1'b1;
  endtask

  initial begin
    bus.imem_ack_i = 0; bus.imem_data_i = '0;
    bus.redirect_i = 0; bus.redirect_pc_i = '0; bus.stall_i = 0;
    m_reset();

    // reset and first fetch
    idle(2);
    chk("rst_req", {31'd0, bus.imem_req_o}, 32'd0);
    chk("rst_addr", bus.imem_addr_o, 32'h100);
    rst = 1'b1;
    idle(1);
    chk("first_req", {31'd0, bus.imem_req_o}, 32'd1);
    chk("first_addr", bus.imem_addr_o, 32'h100);
    cyc(1, 32'h0050_0093, 0, '0, 0);
    chk("next_addr", bus.imem_addr_o, 32'h104);
    chk("no_en_yet", {31'd0, bus.id_en_o}, 32'd0);
    cyc(0, '0, 0, '0, 0);
    chk("first_en", {31'd0, bus.id_en_o}, 32'd1);
    chk("first_pc", bus.pc_o, 32'h100);
    chk("first_inst", bus.inst_o, 32'h0050_0093);

    // backpressure
    do_reset();
    obs_acks = 0;
    for (int i = 0; i < 10; i++) cyc(1, mem_word(m_addr()), 0, '0, 1);
    chk("stall_acks", obs_acks, DEPTH);
    chk("stall_req", {31'd0, bus.imem_req_o}, 32'd0);
    for (int i = 0; i < 12; i++)
      cyc(m_req(), mem_word(m_addr()), 0, '0, 0);

    // redirect with an outstanding request
    do_reset();
    idle(1);
    cyc(0, '0, 1, 32'h20, 0);
    cyc(1, 32'hdead_beef, 0, '0, 0);
    chk("to_20", bus.imem_addr_o, 32'h20);
    cyc(0, '0, 1, 32'h80, 0);
    chk("hold_20", bus.imem_addr_o, 32'h20);
    idle(2);
    chk("hold_20b", bus.imem_addr_o, 32'h20);
    cyc(1, mem_word(32'h20), 0, '0, 0);
    chk("to_80", bus.imem_addr_o, 32'h80);
    idle(2);
    chk("no_en_20", {31'd0, bus.id_en_o}, 32'd0);
    cyc(1, mem_word(32'h80), 0, '0, 0);
    idle(1);
    chk("en_80", {31'd0, bus.id_en_o}, 32'd1);
    chk("pc_80", bus.pc_o, 32'h80);

    // redirect while full, with ack and pop-eligible in the same cycle
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, mem_word(m_addr()), 0, '0, 1);
    cyc(1, '0, 1, 32'h200, 0);
    chk("rdf_en", {31'd0, bus.id_en_o}, 32'd0);
    chk("rdf_addr", bus.imem_addr_o, 32'h200);
    idle(1);
    chk("rdf_empty", {31'd0, bus.id_en_o}, 32'd0);

    // misaligned target and address wrap
    cyc(1, mem_word(32'h200), 1, 32'h0000_0043, 0);
    chk("mis_addr", bus.imem_addr_o, 32'h40);
    cyc(1, mem_word(32'h40), 1, 32'hffff_fffc, 0);
    chk("top_addr", bus.imem_addr_o, 32'hffff_fffc);
    cyc(1, mem_word(32'hffff_fffc), 0, '0, 1);
    chk("wrap_addr", bus.imem_addr_o, 32'h0);

    // async reset between edges
    for (int i = 0; i < 5; i++) cyc(m_req(), mem_word(m_addr()), 0, '0, 0);
    #2 rst = 1'b0;
    #1;
    chk("ar_req", {31'd0, bus.imem_req_o}, 32'd0);
    chk("ar_addr", bus.imem_addr_o, RPC);
    chk("ar_inst", bus.inst_o, 32'd0);
    chk("ar_pc", bus.pc_o, 32'd0);
    chk("ar_en", {31'd0, bus.id_en_o}, 32'd0);
    m_reset();
    @(negedge clk);
    idle(1);
    rst = 1'b1;
    idle(1);
    chk("ar_restart", bus.imem_addr_o, RPC);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      bit a, r, s;
      logic [31:0] t;
      a = m_req() && ($urandom_range(0, 1) == 1);
      r = ($urandom_range(0, 19) == 0);
      s = ($urandom_range(0, 9) < 3);
      t = $urandom;
      if ($urandom_range(0, 3) == 0) t = 32'hffff_fff0 | (t & 32'hf);
      cyc(a, mem_word(m_addr()), r, t, s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
